imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader sitting directly upstream of the Datapath's instruction memory and in front of its reset input.
- Accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory from address 0.
- Pads the unused tail of the memory with a no-op word.
- Holds the core in reset throughout, then releases it so execution starts at address 0. This replaces hierarchical pokes into the instruction memory.

Parameters:
- DATA_W, 16, instruction word width.
- ADDR_W, 8, instruction memory address width (depth 2**ADDR_W = 256).
- PAD_WORD, 16'h0000, fill word for unloaded locations (add R0,R0,R0, a no-op).
- HOLD_CYC, 4, cycles core_rst stays high after the last memory write (minimum 1).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- load_start, input, 1, single-cycle request to begin a load; sampled in IDLE or RUN only.
- in_valid, input, 1, upstream word valid.
- in_data, input, DATA_W, instruction word.
- in_last, input, 1, marks the final word of the program; qualified by the transfer.
- in_ready, output, 1, loader accepts a word this cycle.
- imem_we, output, 1, instruction memory write enable.
- imem_addr, output, ADDR_W, write address.
- imem_wdata, output, DATA_W, write data.
- core_rst, output, 1, active-high reset to the Datapath rst input.
- loading, output, 1, high in LOAD, PAD and HOLD.
- done, output, 1, high in RUN.
- err_overflow, output, 1, sticky: the program exceeded memory depth.
- word_count, output, ADDR_W+1, number of words accepted in the current load (0..256).

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, core_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
  - loading=0, done=0, err_overflow=0, word_count=0.
- All outputs are registered.
- A transfer occurs when in_valid && in_ready at a rising edge.
- States:
  - IDLE: core_rst=1. load_start -> LOAD next cycle; clears the write pointer, word_count and err_overflow.
  - LOAD: in_ready=1.
    - Each transfer writes in_data at the write pointer, with imem_we/imem_addr/imem_wdata appearing the cycle after the transfer (1-cycle latency). The pointer then increments and word_count increments.
    - in_valid=0 simply stalls; there is no timeout.
  - LOAD exit:
    - Transfer with in_last at pointer < 255: in_ready drops the next cycle and the state moves to PAD.
    - Transfer at pointer 255: that word is treated as last and the state moves to HOLD. If in_last=0 on that transfer, err_overflow is set (sticky until the next load_start) and in_ready stays 0, so later words are never accepted.
  - PAD: one write per cycle of PAD_WORD to pointer+1 .. 255, consecutive cycles with imem_we=1. After the write to 255 the state moves to HOLD.
  - HOLD: imem_we=0, core_rst=1 for exactly HOLD_CYC cycles, then RUN.
  - RUN: core_rst=0, done=1. load_start -> LOAD. core_rst rises in the same registered update that enters LOAD, and the pointer, word_count and err_overflow clear.
- load_start is ignored in LOAD, PAD and HOLD.
- core_rst is never 0 in any state except RUN.
- Zero-length programs are not supported. The first transfer always lands at address 0.
- Reset mid-load: returns to IDLE immediately. Partially written memory is not cleared; the next load rewrites all 256 locations.
- Write pointer: ADDR_W bits, never wraps. word_count: ADDR_W+1 bits, saturates at 256.
- Throughput: 1 word/cycle with in_valid held high. Total load time is 256 write cycles regardless of program length, plus HOLD_CYC.

Decomposition:
- Shared package `imem_pkg` holds:
  - the state enum (IDLE, LOAD, PAD, HOLD, RUN);
  - IMEM_ADDR_W=8 and INSTR_W=16;
  - NOP_WORD=16'h0000.
- Datapath and testbenches import the same constants.
- One sub-module is natural: `hold_timer`, a loadable down-counter producing the HOLD exit pulse. Everything else stays in one FSM module.

Test Plan:
- Reset then boot:
  - Stimulus: rst=0 for 3 cycles, release, no load_start.
  - Required: core_rst=1, in_ready=0, done=0 indefinitely.
- Demo program:
  - Stimulus: load_start, then stream 10 words back-to-back (0x2301, 0x21C2, 0x090A, 0x00CA, 0x015C, 0x6585, 0x80C2, 0x2003, 0x4584, 0x105A), in_last on the 10th.
  - Required:
    - imem writes to addresses 0..9 with matching data, each one cycle after its transfer;
    - PAD writes 0x0000 to 10..255;
    - core_rst falls exactly HOLD_CYC=4 cycles after the write to 255;
    - done=1, word_count=10, err_overflow=0.
- Backpressure:
  - Stimulus: in_valid toggled 1,0,0,1,... across 5 words.
  - Required: addresses 0..4 written with no gaps or duplicates; word_count=5.
- Overflow:
  - Stimulus: 300 words, in_last never asserted.
  - Required: exactly 256 transfers, in_ready=0 thereafter, err_overflow=1, no PAD writes, RUN reached after HOLD.
- Reload from RUN:
  - Stimulus: load_start while done=1.
  - Required: core_rst=1 on the next edge, err_overflow and word_count cleared, new program at address 0.
- Async reset mid-PAD:
  - Stimulus: rst=0 while imem_addr=100 in PAD.
  - Required: imem_we=0 and state IDLE without waiting for a clock edge; core_rst stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Constants and FSM encoding shared by the program loader, the Datapath and benches.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int INSTR_W     = 16;

    // add R0,R0,R0 -- architectural no-op used to fill unloaded memory
    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PAD  = 3'd2,
        HOLD = 3'd3,
        RUN  = 3'd4
    } state_t;

    // True while a load sequence is in flight and the core must stay parked
    function automatic logic is_loading(input state_t s);
        return (s == LOAD) || (s == PAD) || (s == HOLD);
    endfunction

endpackage

// File: rtl/imem_loader_hold_timer.sv
// Loadable down-counter that flags the last cycle of the post-load reset hold.
module hold_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    // Preload on entry to the hold window, then count down while enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams instruction words into instruction memory from
// address 0, pads the tail with a no-op, then releases the core from reset.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                 DATA_W   = INSTR_W,
    parameter int                 ADDR_W   = IMEM_ADDR_W,
    parameter logic [DATA_W-1:0]  PAD_WORD = NOP_WORD,
    parameter int                 HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              loading,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    // Hold values run 0..HOLD_CYC-1, so clog2(HOLD_CYC) bits suffice
    localparam int TMR_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TMR_W-1:0]  TMR_LD  = TMR_W'(HOLD_CYC - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              err_n;
    logic [ADDR_W:0]   cnt_n;
    logic              xfer;
    logic              tmr_load;
    logic              tmr_expire;

    assign xfer = in_valid && in_ready;

    hold_timer #(
        .CNT_W (TMR_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TMR_LD),
        .en       (state == HOLD),
        .expire   (tmr_expire)
    );

    // State and write pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    // Next state, next write beat and bookkeeping; a load request from IDLE
    // or RUN restarts the pointer, the word count and the overflow flag
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        we_n     = 1'b0;
        addr_n   = imem_addr;
        wdata_n  = imem_wdata;
        err_n    = err_overflow;
        cnt_n    = word_count;
        tmr_load = 1'b0;

        case (state)
            IDLE, RUN: begin
                if (load_start) begin
                    state_n = LOAD;
                    ptr_n   = '0;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    we_n    = 1'b1;
                    addr_n  = ptr;
                    wdata_n = in_data;
                    if (word_count != CNT_MAX) begin
                        cnt_n = word_count + CNT_ONE;
                    end
                    if (ptr == PTR_MAX) begin
                        // Memory full: this word ends the load whether or not it was last
                        state_n  = HOLD;
                        tmr_load = 1'b1;
                        if (!in_last) begin
                            err_n = 1'b1;
                        end
                    end else begin
                        ptr_n = ptr + PTR_ONE;
                        if (in_last) begin
                            state_n = PAD;
                        end
                    end
                end
            end
            PAD: begin
                we_n    = 1'b1;
                addr_n  = ptr;
                wdata_n = PAD_WORD;
                if (ptr == PTR_MAX) begin
                    state_n  = HOLD;
                    tmr_load = 1'b1;
                end else begin
                    ptr_n = ptr + PTR_ONE;
                end
            end
            HOLD: begin
                if (tmr_expire) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the state being entered so they line
    // up with it; core_rst is low only in RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst     <= 1'b1;
            loading      <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            in_ready     <= (state_n == LOAD);
            imem_we      <= we_n;
            imem_addr    <= addr_n;
            imem_wdata   <= wdata_n;
            core_rst     <= (state_n != RUN);
            loading      <= is_loading(state_n);
            done         <= (state_n == RUN);
            err_overflow <= err_n;
            word_count   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues expected memory writes,
// a negedge monitor pops and compares them as the loader issues writes.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int DW = INSTR_W;
    localparam int AW = IMEM_ADDR_W;
    localparam int HC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          core_rst;
    logic          loading;
    logic          done;
    logic          err_overflow;
    logic [AW:0]   word_count;

    imem_loader #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .PAD_WORD (NOP_WORD),
        .HOLD_CYC (HC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .loading      (loading),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  pcount = 0;
    int  exp_ptr = 0;
    int  last_cyc = 0;
    int  nacc = 0;

    logic [DW-1:0] demo [10] = '{16'h2301, 16'h21C2, 16'h090A, 16'h00CA, 16'h015C,
                                 16'h6585, 16'h80C2, 16'h2003, 16'h4584, 16'h105A};
    logic [DW-1:0] bp   [5]  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    always @(posedge clk) pcount <= pcount + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: every write the loader issues must match the head of the queue
    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", 32'(imem_wdata), 32'(e.data));
                chk("wr_cycle", 32'(pcount), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; a word offered while in_ready is high transfers at
    // the next posedge and its write is visible one cycle later.
    task automatic send_word(input logic [DW-1:0] d, input logic last, output bit ok);
        wr_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok       = 1'b0;
        if (in_ready === 1'b1) begin
            e.addr = AW'(exp_ptr);
            e.data = d;
            e.cyc  = pcount + 1;
            exp_q.push_back(e);
            last_cyc = pcount + 1;
            exp_ptr++;
            nacc++;
            ok = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_pads();
        wr_t e;
        for (int a = exp_ptr; a < 256; a++) begin
            last_cyc++;
            e.addr = AW'(a);
            e.data = NOP_WORD;
            e.cyc  = last_cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        exp_ptr = 0;
        nacc    = 0;
    endtask

    // core_rst must first read low exactly HC cycles after the final write
    task automatic wait_run();
        int  exp_fall;
        bit  seen;
        exp_fall = last_cyc + HC;
        seen     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (core_rst === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now("run_timeout");
        else chk("core_rst_fall_cycle", 32'(pcount), 32'(exp_fall));
    endtask

    initial begin
        bit ok;
        bit hit;

        // Reset then idle with no load request
        repeat (3) @(negedge clk);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_core_rst", 32'(core_rst), 32'd1);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_loading", 32'(loading), 32'd0);

        // Demo program, back-to-back
        start_load();
        chk("load_in_ready", 32'(in_ready), 32'd1);
        chk("load_loading", 32'(loading), 32'd1);
        for (int i = 0; i < 10; i++) begin
            send_word(demo[i], (i == 9), ok);
            if (!ok) fail_now("demo_in_ready_low");
        end
        push_pads();
        wait_run();
        chk("demo_done", 32'(done), 32'd1);
        chk("demo_word_count", 32'(word_count), 32'd10);
        chk("demo_err", 32'(err_overflow), 32'd0);
        chk("demo_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: in_valid pattern 1,0,0,1,0,0,...
        start_load();
        for (int i = 0; i < 5; i++) begin
            if (i != 0) repeat (2) @(negedge clk);
            send_word(bp[i], (i == 4), ok);
            if (!ok) fail_now("bp_in_ready_low");
        end
        push_pads();
        wait_run();
        chk("bp_word_count", 32'(word_count), 32'd5);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: 300 words offered, in_last never set
        start_load();
        for (int i = 0; i < 300; i++) begin
            send_word(DW'(16'hA000 + i), 1'b0, ok);
            if (!ok) break;
        end
        chk("ovf_accepted", 32'(nacc), 32'd256);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_err", 32'(err_overflow), 32'd1);
        wait_run();
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_word_count", 32'(word_count), 32'd256);
        chk("ovf_err_sticky", 32'(err_overflow), 32'd1);
        chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reload from RUN
        start_load();
        chk("reload_core_rst", 32'(core_rst), 32'd1);
        chk("reload_err_clr", 32'(err_overflow), 32'd0);
        chk("reload_count_clr", 32'(word_count), 32'd0);
        chk("reload_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send_word(DW'(16'h7000 + i), (i == 2), ok);
            if (!ok) fail_now("reload_in_ready_low");
        end
        push_pads();

        // Async reset while PAD writes address 100
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (imem_we === 1'b1 && imem_addr == AW'(100)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hit) fail_now("pad_addr100_timeout");
        #2 rst = 1'b0;
        #1;
        chk("arst_imem_we", 32'(imem_we), 32'd0);
        chk("arst_core_rst", 32'(core_rst), 32'd1);
        chk("arst_loading", 32'(loading), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_count", 32'(word_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_arst_core_rst", 32'(core_rst), 32'd1);
        chk("post_arst_done", 32'(done), 32'd0);
        chk("post_arst_we", 32'(imem_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
